// File: rtl/mu0_sequencer.sv
// MU0 instruction sequencer: configurable phases per instruction, memory wait
// states, halt/restart, single-step pause and a retired-instruction counter.
module mu0_sequencer #(
  parameter int NUM_PHASES = 2,
  parameter int PHASE_W    = 1,
  parameter int CNT_W      = 16
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Halt,
  input  logic               Run,
  input  logic               Mem_Ready,
  input  logic               Step_Mode,
  input  logic               Step,
  output logic [PHASE_W-1:0] phase,
  output logic               Running,
  output logic               Fetch,
  output logic               Last_Phase,
  output logic               Halted,
  output logic               Paused,
  output logic [CNT_W-1:0]   Instr_Count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               at_last;

  assign at_last = (phase_q == LAST_PHASE);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_RUN;
      phase_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        // Mem_Ready low freezes phase, state and counter alike.
        if (Mem_Ready) begin
          if (at_last) begin
            phase_d = '0;
            count_d = count_q + CNT_W'(1);
            if (Halt)
              state_d = ST_HALTED;
            else if (Step_Mode)
              state_d = ST_PAUSED;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
      end
      ST_HALTED: begin
        phase_d = '0;
        if (Run)
          state_d = ST_RUN;
      end
      ST_PAUSED: begin
        phase_d = '0;
        if (Step || !Step_Mode)
          state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        phase_d = '0;
      end
    endcase
  end

  assign phase       = phase_q;
  assign Running     = (state_q == ST_RUN);
  assign Fetch       = (state_q == ST_RUN) && (phase_q == '0);
  assign Last_Phase  = (state_q == ST_RUN) && at_last;
  assign Halted      = (state_q == ST_HALTED);
  assign Paused      = (state_q == ST_PAUSED);
  assign Instr_Count = count_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed scoreboard bench for mu0_sequencer (3 phases, 4-bit counter).
module tb_mu0_sequencer;

  localparam int NP = 3;
  localparam int R  = 0;
  localparam int H  = 1;
  localparam int P  = 2;

  typedef struct {
    int ph;
    int st;
    int cnt;
  } exp_t;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       Halt, Run, Mem_Ready, Step_Mode, Step;
  logic [1:0] phase;
  logic       Running, Fetch, Last_Phase, Halted, Paused;
  logic [3:0] Instr_Count;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   nstep  = 0;

  mu0_sequencer #(.NUM_PHASES(NP), .PHASE_W(2), .CNT_W(4)) dut (
    .Clk(Clk), .nReset(nReset), .Halt(Halt), .Run(Run),
    .Mem_Ready(Mem_Ready), .Step_Mode(Step_Mode), .Step(Step),
    .phase(phase), .Running(Running), .Fetch(Fetch), .Last_Phase(Last_Phase),
    .Halted(Halted), .Paused(Paused), .Instr_Count(Instr_Count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic compare_out();
    exp_t e;
    logic run;
    nstep++;
    if (q.size() == 0) begin
      chk($sformatf("s%0d_queue_empty", nstep), 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    run = (e.st == R);
    chk($sformatf("s%0d_phase", nstep),      32'(phase),       32'(e.ph));
    chk($sformatf("s%0d_Running", nstep),    32'(Running),     32'(run));
    chk($sformatf("s%0d_Fetch", nstep),      32'(Fetch),       32'(run && e.ph == 0));
    chk($sformatf("s%0d_Last_Phase", nstep), 32'(Last_Phase),  32'(run && e.ph == NP - 1));
    chk($sformatf("s%0d_Halted", nstep),     32'(Halted),      32'(e.st == H));
    chk($sformatf("s%0d_Paused", nstep),     32'(Paused),      32'(e.st == P));
    chk($sformatf("s%0d_Instr_Count", nstep), 32'(Instr_Count), 32'(e.cnt));
  endtask

  // Drive one cycle of inputs, queue the state expected after the next edge.
  task automatic cyc(input logic h, r, mr, sm, st, input int ph, input int s, input int c);
    Halt = h; Run = r; Mem_Ready = mr; Step_Mode = sm; Step = st;
    q.push_back('{ph, s, c});
    @(posedge Clk);
    #1;
    compare_out();
  endtask

  initial begin
    nReset = 1'b0;
    Halt = 1'b0; Run = 1'b0; Mem_Ready = 1'b1; Step_Mode = 1'b0; Step = 1'b0;
    #2;
    q.push_back('{0, R, 0});
    compare_out();
    #6;
    nReset = 1'b1;

    // Free run
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, (i + 1) % NP, R, (i + 1) / NP);

    // Wait states
    cyc(0, 0, 1, 0, 0, 1, R, 3);
    cyc(0, 0, 1, 0, 0, 2, R, 3);
    cyc(0, 0, 0, 0, 0, 2, R, 3);
    cyc(0, 0, 0, 0, 0, 2, R, 3);
    cyc(0, 0, 1, 0, 0, 0, R, 4);
    cyc(0, 0, 0, 0, 0, 0, R, 4);

    // Halt sampled only on boundary, then ignores everything but Run
    cyc(1, 0, 1, 0, 0, 1, R, 4);
    cyc(1, 0, 1, 0, 0, 2, R, 4);
    cyc(1, 0, 0, 0, 0, 2, R, 4);
    cyc(1, 0, 1, 0, 0, 0, H, 5);
    cyc(1, 0, 0, 1, 1, 0, H, 5);
    cyc(0, 0, 1, 1, 1, 0, H, 5);
    cyc(1, 0, 1, 0, 0, 0, H, 5);
    cyc(0, 0, 1, 0, 0, 0, H, 5);
    cyc(1, 1, 1, 0, 0, 0, R, 5);
    cyc(0, 1, 1, 0, 0, 1, R, 5);
    cyc(0, 0, 1, 0, 0, 2, R, 5);
    cyc(0, 0, 1, 0, 0, 0, R, 6);

    // Single step
    cyc(0, 0, 1, 1, 0, 1, R, 6);
    cyc(0, 0, 1, 1, 0, 2, R, 6);
    cyc(0, 0, 1, 1, 0, 0, P, 7);
    cyc(0, 0, 1, 1, 0, 0, P, 7);
    cyc(0, 1, 0, 1, 0, 0, P, 7);
    cyc(0, 0, 1, 1, 1, 0, R, 7);
    cyc(0, 0, 1, 1, 1, 1, R, 7);
    cyc(0, 0, 0, 1, 0, 1, R, 7);
    cyc(0, 0, 1, 1, 0, 2, R, 7);
    cyc(0, 0, 1, 1, 0, 0, P, 8);
    cyc(0, 0, 1, 0, 0, 0, R, 8);
    cyc(0, 0, 1, 0, 0, 1, R, 8);
    cyc(0, 0, 1, 0, 0, 2, R, 8);
    cyc(0, 0, 1, 0, 0, 0, R, 9);

    // Count up to 15, then Halt+Step_Mode at the 16th boundary wraps and halts
    for (int i = 0; i < 18; i++) cyc(0, 0, 1, 0, 0, (i + 1) % NP, R, 9 + (i + 1) / NP);
    cyc(1, 0, 1, 1, 0, 1, R, 15);
    cyc(1, 0, 1, 1, 0, 2, R, 15);
    cyc(1, 0, 1, 1, 0, 0, H, 0);
    cyc(0, 1, 1, 0, 0, 0, R, 0);
    cyc(0, 0, 1, 0, 0, 1, R, 0);
    cyc(0, 0, 1, 0, 0, 2, R, 0);
    cyc(0, 0, 1, 0, 0, 0, R, 1);
    cyc(0, 0, 1, 0, 0, 1, R, 1);
    cyc(0, 0, 1, 0, 0, 2, R, 1);
    cyc(0, 0, 0, 0, 0, 2, R, 1);

    // Async reset mid-instruction during a wait state, between clock edges
    #2;
    nReset = 1'b0;
    #1;
    q.push_back('{0, R, 0});
    compare_out();
    #2;
    nReset = 1'b1;
    cyc(0, 0, 1, 0, 0, 1, R, 0);
    cyc(0, 0, 1, 0, 0, 2, R, 0);
    cyc(0, 0, 1, 0, 0, 0, R, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mu0_sequencer.md
# mu0_sequencer

Parametrised instruction sequencer for the MU0 processor family. It supersedes the fixed two-state fetch/execute controller with a configurable number of phases per instruction, memory wait states, an explicit halt/restart protocol, a single-step debug mode and a retired-instruction counter. It sits between the instruction decoder/datapath and the memory interface, and drives the phase number that the decoder uses to generate datapath control signals.

## Interface
Parameters:
- NUM_PHASES, 2, phases per instruction; legal range 2..8.
- PHASE_W, 1, width of `phase`; must satisfy NUM_PHASES <= 2**PHASE_W.
- CNT_W, 16, width of the retired-instruction counter; legal range 1..32.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  asynchronous reset, active-low.
- Halt  input  1  level; asserted by the decoder while a STP instruction is in progress.
- Run  input  1  single-cycle pulse; restarts execution from the HALTED state.
- Mem_Ready  input  1  memory ready. When it is 0, the current phase is held as a wait state.
- Step_Mode  input  1  level; 1 selects single-step execution.
- Step  input  1  single-cycle pulse; releases exactly one instruction while in PAUSED.
- phase  output  PHASE_W  current phase number, 0..NUM_PHASES-1.
- Running  output  1  1 when the control state is RUN.
- Fetch  output  1  Running and phase==0.
- Last_Phase  output  1  Running and phase==NUM_PHASES-1.
- Halted  output  1  1 when the control state is HALTED.
- Paused  output  1  1 when the control state is PAUSED.
- Instr_Count  output  CNT_W  number of retired instructions.

## Operation
The control FSM has three states: RUN, HALTED and PAUSED.

Boundary event:
- Defined as a cycle with Last_Phase=1 and Mem_Ready=1. This is the cycle in which an instruction retires.

RUN:
- If Mem_Ready=1 and this is not a boundary, `phase` increments by 1.
- If Mem_Ready=0, `phase`, the state and the counter all hold.
- On a boundary:
  - `phase` returns to 0.
  - Instr_Count increments by 1, wrapping modulo 2**CNT_W.
  - The next state is chosen by priority: Halt=1 → HALTED; otherwise Step_Mode=1 → PAUSED; otherwise stay in RUN.
- Halt is sampled only on a boundary. Halt asserted in any other phase has no effect until the boundary.

HALTED:
- `phase` is held at 0.
- Run=1 → RUN.
- Halt, Step, Step_Mode and Mem_Ready are ignored.

PAUSED:
- `phase` is held at 0.
- Step=1 → RUN. Exactly one instruction then executes, because Step_Mode is still 1 at its boundary.
- Step_Mode=0 → RUN. This is free-running resume.
- Run is ignored.

Other rules:
- All outputs are derived from registered state only. No output depends combinationally on an input.
- Instr_Count changes only on boundary cycles.
- Asynchronous reset can occur at any point, including mid-instruction or during a wait state. It forces:
  - state=RUN
  - phase=0
  - Instr_Count=0

## Timing
Reset values:
- phase=0
- Running=1
- Fetch=1
- Last_Phase=0
- Halted=0
- Paused=0
- Instr_Count=0

The outputs are therefore Running=1 and Fetch=1 while nReset is still low.

Latency and throughput:
- Phase advance takes effect in the cycle after the enabling edge.
- With Mem_Ready tied to 1, one instruction takes exactly NUM_PHASES cycles.
- Each Mem_Ready=0 cycle adds exactly one cycle.

Halt:
- Halted=1 from the cycle after the boundary edge.
- Running=0 in that same cycle.
- Instr_Count already includes the halting instruction.

Run:
- A pulse in HALTED gives Fetch=1 in the following cycle.
- The Run pulse must be at least 1 cycle wide. A longer pulse causes no extra effect.

Step:
- A pulse in PAUSED gives Running=1 for exactly NUM_PHASES cycles (plus any wait states).
- Paused then returns to 1.
- A Step pulse while in RUN is ignored.

Simultaneous events:
- Halt=1 with Step_Mode=1 at a boundary → HALTED.
- Run=1 with Halt=1 while HALTED → RUN.

Reset mid-operation:
- Release of nReset is synchronised outside this block. The first active edge after release behaves as RUN with phase=0.

## Test plan
- Reset and free run: NUM_PHASES=3, Mem_Ready=1, 9 cycles → phase sequence 0,1,2,0,1,2,0,1,2; Instr_Count=3; Fetch=1 on cycles 0, 3 and 6 only.
- Wait states: NUM_PHASES=2, Mem_Ready=0 for 2 cycles during phase 1 → phase stays at 1 for 3 cycles; Instr_Count increments once, after Mem_Ready returns to 1.
- Halt and restart: Halt=1 asserted in phase 0 → no effect until the phase-1 boundary; then Halted=1, phase=0 and Instr_Count=N+1. Run pulse 5 cycles later → Fetch=1 on the next cycle and Halted=0.
- Single step: Step_Mode=1 → Paused=1 after the current boundary. Each Step pulse retires exactly one instruction (Instr_Count +1). Clearing Step_Mode while PAUSED → RUN the next cycle.
- Priority and wrap: CNT_W=4, with Halt=1 and Step_Mode=1 both asserted at the 16th boundary → HALTED (not PAUSED) and Instr_Count wraps from 15 to 0.
- Async reset mid-instruction: NUM_PHASES=4, nReset low in phase 2 during a wait state → immediately phase=0, Instr_Count=0, Running=1 and Halted=0, without waiting for a clock edge.
